reg_mem_sb: RTL and testbench

REG_MEM_SB -- requirements
Module: reg_mem_sb

---
 rtl/reg_mem_sb_if.sv | 33 +++
 rtl/reg_mem_sb.sv | 136 +++++++++++++
 tb/tb_reg_mem_sb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_mem_sb_if.sv
// Bus bundle for the scoreboarded register file: read ports, write-back commit,
// issue marking and status flags.
interface reg_mem_sb_if #(
  parameter int REG_WIDTH  = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] ReadReg1;
  logic [ADDR_WIDTH-1:0] ReadReg2;
  logic [REG_WIDTH-1:0]  Reg1Data;
  logic [REG_WIDTH-1:0]  Reg2Data;
  logic                  WrEn;
  logic [1:0]            Mode;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [REG_WIDTH-1:0]  WriteData;
  logic [7:0]            Imm;
  logic [REG_WIDTH-1:0]  PC;
  logic                  IssueEn;
  logic [ADDR_WIDTH-1:0] IssueReg;
  logic                  Stall;
  logic                  err;

  modport master (
    output ReadReg1, ReadReg2, WrEn, Mode, WriteReg, WriteData, Imm, PC,
           IssueEn, IssueReg,
    input  Reg1Data, Reg2Data, Stall, err
  );

  modport slave (
    input  ReadReg1, ReadReg2, WrEn, Mode, WriteReg, WriteData, Imm, PC,
           IssueEn, IssueReg,
    output Reg1Data, Reg2Data, Stall, err
  );
endinterface

// File: rtl/reg_mem_sb.sv
// Register file with mode-selected write-back, same-cycle read bypass and a
// per-register pending scoreboard that stalls reads of not-yet-written registers.
module reg_mem_sb #(
  parameter int REG_WIDTH  = 16,
  parameter int REG_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int LINK_REG   = 7
) (
  input  logic        clk,
  input  logic        rst,
  reg_mem_sb_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_LBI    = 2'b01,
    MODE_SLBI   = 2'b10,
    MODE_LINK   = 2'b11
  } mode_e;

  logic [REG_WIDTH-1:0]  regs_r [REG_DEPTH];
  logic [REG_DEPTH-1:0]  busy_r;
  logic                  err_r;

  logic [REG_WIDTH-1:0]  stored1_s;
  logic [REG_WIDTH-1:0]  stored2_s;
  logic [ADDR_WIDTH-1:0] eff_dest_s;
  logic [REG_WIDTH-1:0]  eff_data_s;
  logic                  wr_ok_s;
  logic                  wr_bad_s;
  logic                  iss_ok_s;
  logic                  iss_bad_s;
  logic [REG_DEPTH-1:0]  clr_mask_s;
  logic [REG_DEPTH-1:0]  set_mask_s;
  logic [REG_WIDTH-1:0]  rd1_s;
  logic [REG_WIDTH-1:0]  rd2_s;
  logic                  stall_s;

  function automatic logic is_legal(input logic [ADDR_WIDTH-1:0] addr);
    return 32'(addr) < 32'(REG_DEPTH);
  endfunction

  // Pre-edge register contents per read port; out-of-range addresses read zero
  always_comb begin
    stored1_s = '0;
    stored2_s = '0;
    if (is_legal(bus.ReadReg1)) stored1_s = regs_r[bus.ReadReg1];
    else                        stored1_s = '0;
    if (is_legal(bus.ReadReg2)) stored2_s = regs_r[bus.ReadReg2];
    else                        stored2_s = '0;
  end

  // Effective destination and data for the write-back mode
  always_comb begin
    eff_dest_s = bus.WriteReg;
    eff_data_s = bus.WriteData;
    case (mode_e'(bus.Mode))
      MODE_NORMAL: begin
        eff_dest_s = bus.WriteReg;
        eff_data_s = bus.WriteData;
      end
      MODE_LBI: begin
        eff_dest_s = bus.ReadReg1;
        eff_data_s = {{(REG_WIDTH-8){bus.Imm[7]}}, bus.Imm};
      end
      MODE_SLBI: begin
        // Shifts the stored value, never the bypassed one
        eff_dest_s = bus.ReadReg1;
        eff_data_s = (stored1_s << 8) | {{(REG_WIDTH-8){1'b0}}, bus.Imm};
      end
      MODE_LINK: begin
        eff_dest_s = ADDR_WIDTH'(LINK_REG);
        eff_data_s = bus.PC + REG_WIDTH'(2);
      end
      default: begin
        eff_dest_s = bus.WriteReg;
        eff_data_s = bus.WriteData;
      end
    endcase
  end

  // Legality of this cycle's commit and issue, plus scoreboard update masks
  always_comb begin
    wr_ok_s    = bus.WrEn & is_legal(eff_dest_s);
    wr_bad_s   = bus.WrEn & ~is_legal(eff_dest_s);
    iss_ok_s   = bus.IssueEn & is_legal(bus.IssueReg);
    iss_bad_s  = bus.IssueEn & ~is_legal(bus.IssueReg);
    clr_mask_s = '0;
    set_mask_s = '0;
    if (wr_ok_s) clr_mask_s[eff_dest_s] = 1'b1;
    else         clr_mask_s = '0;
    if (iss_ok_s) set_mask_s[bus.IssueReg] = 1'b1;
    else          set_mask_s = '0;
  end

  // Read ports with bypass, and operand-pending stall
  always_comb begin
    rd1_s   = stored1_s;
    rd2_s   = stored2_s;
    stall_s = 1'b0;
    if (wr_ok_s && (bus.ReadReg1 == eff_dest_s)) rd1_s = eff_data_s;
    else                                         rd1_s = stored1_s;
    if (wr_ok_s && (bus.ReadReg2 == eff_dest_s)) rd2_s = eff_data_s;
    else                                         rd2_s = stored2_s;
    stall_s = (is_legal(bus.ReadReg1) && busy_r[bus.ReadReg1] &&
               !(wr_ok_s && (bus.ReadReg1 == eff_dest_s))) ||
              (is_legal(bus.ReadReg2) && busy_r[bus.ReadReg2] &&
               !(wr_ok_s && (bus.ReadReg2 == eff_dest_s)));
  end

  // Register storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_r[i] <= '0;
    end else if (wr_ok_s) begin
      regs_r[eff_dest_s] <= eff_data_s;
    end
  end

  // Scoreboard busy bits (set overrides clear) and sticky illegal-address flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= '0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
      err_r  <= err_r | wr_bad_s | iss_bad_s;
    end
  end

  assign bus.Reg1Data = rd1_s;
  assign bus.Reg2Data = rd2_s;
  assign bus.Stall    = stall_s;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_reg_mem_sb.sv
// Bench for reg_mem_sb: a directed vector table, hand sequences for illegal
// addresses and asynchronous reset, then random traffic against an array model.
`timescale 1ns/1ps
module tb_reg_mem_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  rr1, rr2, wreg, isr;
  logic        wren, issen;
  logic [1:0]  mode;
  logic [15:0] wdata, pc;
  logic [7:0]  imm;

  int checks = 0;
  int failures = 0;

  reg_mem_sb_if #(.REG_WIDTH(16), .ADDR_WIDTH(3)) ifa ();
  reg_mem_sb_if #(.REG_WIDTH(16), .ADDR_WIDTH(3)) ifb ();

  assign ifa.ReadReg1 = rr1;   assign ifb.ReadReg1 = rr1;
  assign ifa.ReadReg2 = rr2;   assign ifb.ReadReg2 = rr2;
  assign ifa.WrEn = wren;      assign ifb.WrEn = wren;
  assign ifa.Mode = mode;      assign ifb.Mode = mode;
  assign ifa.WriteReg = wreg;  assign ifb.WriteReg = wreg;
  assign ifa.WriteData = wdata; assign ifb.WriteData = wdata;
  assign ifa.Imm = imm;        assign ifb.Imm = imm;
  assign ifa.PC = pc;          assign ifb.PC = pc;
  assign ifa.IssueEn = issen;  assign ifb.IssueEn = issen;
  assign ifa.IssueReg = isr;   assign ifb.IssueReg = isr;

  reg_mem_sb #(.REG_WIDTH(16), .REG_DEPTH(8), .ADDR_WIDTH(3), .LINK_REG(7))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  reg_mem_sb #(.REG_WIDTH(16), .REG_DEPTH(6), .ADDR_WIDTH(3), .LINK_REG(5))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct packed {
    logic        wren;
    logic [1:0]  mode;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic [7:0]  imm;
    logic [15:0] pc;
    logic [2:0]  rr1, rr2;
    logic        issen;
    logic [2:0]  isr;
    logic [15:0] e1, e2;
    logic        estall;
  } vec_t;
  vec_t tbl [22];

  // Reference model state, index 0 = 8-deep instance, 1 = 6-deep instance
  int unsigned m_reg [2][8];
  bit          m_busy[2][8];
  bit          m_err [2];

  function automatic int depth_of(input int d); return (d == 0) ? 8 : 6; endfunction
  function automatic int link_of(input int d);  return (d == 0) ? 7 : 5; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rr1 = 3'd0; rr2 = 3'd0; wreg = 3'd0; isr = 3'd0; wren = 1'b0; issen = 1'b0;
    mode = 2'd0; wdata = 16'h0000; pc = 16'h0000; imm = 8'h00;
  endtask

  task automatic model_eff(input int d, output bit ok, output int dst, output int unsigned val);
    int unsigned base;
    base = 0;
    case (mode)
      2'd0: begin dst = int'(wreg); val = wdata; end
      2'd1: begin dst = int'(rr1); val = (imm < 128) ? int'(imm) : int'(imm) + 65280; end
      2'd2: begin
        dst  = int'(rr1);
        base = (dst < depth_of(d)) ? m_reg[d][dst] : 0;
        val  = (base * 256 + int'(imm)) % 65536;
      end
      default: begin dst = link_of(d); val = (int'(pc) + 2) % 65536; end
    endcase
    ok = wren && (dst < depth_of(d));
  endtask

  function automatic int unsigned model_read(input int d, input int a, input bit ok,
                                             input int dst, input int unsigned val);
    if (ok && a == dst) return val;
    if (a < depth_of(d)) return m_reg[d][a];
    return 0;
  endfunction

  function automatic bit model_pending(input int d, input int a, input bit ok, input int dst);
    return (a < depth_of(d)) && m_busy[d][a] && !(ok && a == dst);
  endfunction

  task automatic model_cmp(input int d, input int n, input logic [15:0] r1, input logic [15:0] r2,
                           input logic st, input logic er);
    bit ok; int dst; int unsigned val;
    model_eff(d, ok, dst, val);
    check($sformatf("rnd%0d dut%0d Reg1Data", n, d), r1, model_read(d, int'(rr1), ok, dst, val));
    check($sformatf("rnd%0d dut%0d Reg2Data", n, d), r2, model_read(d, int'(rr2), ok, dst, val));
    check($sformatf("rnd%0d dut%0d Stall", n, d), st,
          model_pending(d, int'(rr1), ok, dst) || model_pending(d, int'(rr2), ok, dst));
    check($sformatf("rnd%0d dut%0d err", n, d), er, m_err[d]);
  endtask

  task automatic model_step(input int d);
    bit ok; int dst; int unsigned val;
    model_eff(d, ok, dst, val);
    if (wren) begin
      if (ok) begin m_reg[d][dst] = val; m_busy[d][dst] = 1'b0; end
      else m_err[d] = 1'b1;
    end
    if (issen) begin
      if (int'(isr) < depth_of(d)) m_busy[d][isr] = 1'b1;
      else m_err[d] = 1'b1;
    end
  endtask

  initial begin
    //           wren  mode  wreg  wdata     imm    pc        rr1   rr2   iss   isr   e1        e2        stall
    tbl[0]  = '{1'b1, 2'd0, 3'd3, 16'hBEEF, 8'h00, 16'h0000, 3'd3, 3'd0, 1'b0, 3'd0, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd3, 3'd3, 1'b0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 3'd0, 16'h0000, 8'h80, 16'h0000, 3'd2, 3'd2, 1'b0, 3'd0, 16'hFF80, 16'hFF80, 1'b0};
    tbl[3]  = '{1'b1, 2'd2, 3'd0, 16'h0000, 8'h12, 16'h0000, 3'd2, 3'd3, 1'b0, 3'd0, 16'h8012, 16'hBEEF, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd2, 3'd0, 1'b0, 3'd0, 16'h8012, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 2'd3, 3'd0, 16'h0000, 8'h00, 16'hFFFF, 3'd7, 3'd2, 1'b0, 3'd0, 16'h0001, 16'h8012, 1'b0};
    tbl[6]  = '{1'b1, 2'd3, 3'd0, 16'h0000, 8'h00, 16'h1000, 3'd7, 3'd7, 1'b0, 3'd0, 16'h1002, 16'h1002, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd7, 3'd3, 1'b0, 3'd0, 16'h1002, 16'hBEEF, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b1, 3'd4, 16'h0000, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1};
    tbl[10] = '{1'b1, 2'd0, 3'd4, 16'h5A5A, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b0, 3'd0, 16'h0000, 16'h5A5A, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b0, 3'd0, 16'h0000, 16'h5A5A, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b1, 3'd4, 16'h0000, 16'h5A5A, 1'b0};
    tbl[13] = '{1'b1, 2'd0, 3'd4, 16'h1111, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b1, 3'd4, 16'h0000, 16'h1111, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b0, 3'd0, 16'h0000, 16'h1111, 1'b1};
    tbl[15] = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b1, 3'd4, 16'h0000, 16'h1111, 1'b1};
    tbl[16] = '{1'b1, 2'd0, 3'd4, 16'h2222, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b0, 3'd0, 16'h0000, 16'h2222, 1'b0};
    tbl[17] = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd0, 3'd4, 1'b0, 3'd0, 16'h0000, 16'h2222, 1'b0};
    tbl[18] = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b1, 3'd1, 16'h0000, 16'h0000, 1'b0};
    tbl[19] = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd1, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1};
    tbl[20] = '{1'b1, 2'd0, 3'd1, 16'h1234, 8'h00, 16'h0000, 3'd1, 3'd0, 1'b1, 3'd1, 16'h1234, 16'h0000, 1'b0};
    tbl[21] = '{1'b0, 2'd0, 3'd0, 16'h0000, 8'h00, 16'h0000, 3'd1, 3'd0, 1'b0, 3'd0, 16'h1234, 16'h0000, 1'b1};

    // Power-on reset: every address reads zero, no stall, no error
    rst = 1'b0;
    idle();
    #1;
    for (int a = 0; a < 8; a++) begin
      rr1 = 3'(a); rr2 = 3'(7 - a);
      #1;
      check($sformatf("reset rd a%0d", a), {ifa.Reg1Data, ifa.Reg2Data}, 32'h0);
    end
    check("reset Stall", ifa.Stall, 32'h0);
    check("reset err a", ifa.err, 32'h0);
    check("reset err b", ifb.err, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 22; i++) begin
      wren = tbl[i].wren; mode = tbl[i].mode; wreg = tbl[i].wreg; wdata = tbl[i].wdata;
      imm = tbl[i].imm; pc = tbl[i].pc; rr1 = tbl[i].rr1; rr2 = tbl[i].rr2;
      issen = tbl[i].issen; isr = tbl[i].isr;
      #1;
      check($sformatf("vec%0d Reg1Data", i), ifa.Reg1Data, tbl[i].e1);
      check($sformatf("vec%0d Reg2Data", i), ifa.Reg2Data, tbl[i].e2);
      check($sformatf("vec%0d Stall", i), ifa.Stall, tbl[i].estall);
      tick();
    end

    // Illegal write on the 6-deep instance: dropped, err sticky from next cycle
    idle(); wren = 1'b1; wreg = 3'd7; wdata = 16'hFFFF; rr1 = 3'd7; rr2 = 3'd2;
    #1;
    check("b illegal no bypass", ifb.Reg1Data, 32'h0);
    check("b r2 before", ifb.Reg2Data, 32'h8012);
    check("b err same cycle", ifb.err, 32'h0);
    tick();
    idle(); rr1 = 3'd5; rr2 = 3'd2;
    #1;
    check("b r5 kept", ifb.Reg1Data, 32'h1002);
    check("b r2 kept", ifb.Reg2Data, 32'h8012);
    check("b err set", ifb.err, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("b err sticky %0d", k), ifb.err, 32'h1);
    end

    // Asynchronous reset between edges
    idle(); rr1 = 3'd1;
    #1;
    check("pre-reset r1", ifa.Reg1Data, 32'h1234);
    check("pre-reset Stall", ifa.Stall, 32'h1);
    check("pre-reset err b", ifb.err, 32'h1);
    #1 rst = 1'b0;
    #1;
    check("async r1", ifa.Reg1Data, 32'h0);
    check("async Stall", ifa.Stall, 32'h0);
    check("async err b", ifb.err, 32'h0);
    check("async err a", ifa.err, 32'h0);
    tick();
    // Write and issue under reset: bypass still visible, nothing retained
    wren = 1'b1; wreg = 3'd3; wdata = 16'h7777; rr1 = 3'd3; issen = 1'b1; isr = 3'd3;
    #1;
    check("reset bypass", ifa.Reg1Data, 32'h7777);
    check("reset bypass Stall", ifa.Stall, 32'h0);
    tick();
    idle(); rr1 = 3'd3; rst = 1'b1;
    #1;
    check("reset write dropped", ifa.Reg1Data, 32'h0);
    check("reset issue dropped", ifa.Stall, 32'h0);
    tick();

    for (int d = 0; d < 2; d++) begin
      m_err[d] = 1'b0;
      for (int a = 0; a < 8; a++) begin m_reg[d][a] = 0; m_busy[d][a] = 1'b0; end
    end
    for (int n = 0; n < 400; n++) begin
      wren  = 1'($urandom_range(0, 1));
      mode  = 2'($urandom_range(0, 3));
      wreg  = 3'($urandom_range(0, 7));
      wdata = 16'($urandom);
      imm   = 8'($urandom);
      pc    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rr1   = 3'($urandom_range(0, 7));
      rr2   = 3'($urandom_range(0, 7));
      issen = ($urandom_range(0, 9) < 3);
      isr   = 3'($urandom_range(0, 7));
      #1;
      model_cmp(0, n, ifa.Reg1Data, ifa.Reg2Data, ifa.Stall, ifa.err);
      model_cmp(1, n, ifb.Reg1Data, ifb.Reg2Data, ifb.Stall, ifb.err);
      model_step(0);
      model_step(1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
